alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Sequential front-end and result stage wrapped around the combinational 16-bit ALU (command codes 1=add, 2=sub, 3=mul, 4=div, 5=mod; 32-bit result; 2-bit error {dbz, overflow}).
- Accepts operations over a valid/ready handshake and drives the ALU operand and command inputs from registers.
- Waits a fixed settle time, captures the ALU result and error, and presents them downstream over a second valid/ready handshake.
- Keeps an accumulator for chained operations, a sticky error register and an operation counter.

Parameters:
SETTLE, 2, cycles the ALU inputs are held before capture; legal range 1..15.
CNT_W, 16, width of op_count.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  upstream operation valid.
in_ready  out  1  sequencer can accept an operation.
in_a  in  16  operand A.
in_b  in  16  operand B.
in_cmd  in  4  ALU command code.
in_use_acc  in  1  1 = use acc[15:0] as operand A instead of in_a.
alu_a  out  16  registered operand A to the ALU.
alu_b  out  16  registered operand B to the ALU.
alu_cmd  out  4  registered command to the ALU.
alu_result  in  32  ALU result.
alu_error  in  2  ALU error {dbz, overflow}.
out_valid  out  1  captured result valid.
out_ready  in  1  downstream accepts the result.
out_result  out  32  captured result.
out_error  out  2  captured error.
acc  out  32  accumulator.
sticky_err  out  2  OR of all captured errors since reset or the last clear.
clr_sticky  in  1  synchronous clear of sticky_err.
op_count  out  CNT_W  number of completed captures, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; alu_a, alu_b, alu_cmd, out_result, out_error, acc, sticky_err, op_count = 0; out_valid = 0; in_ready = 1 once state is IDLE. alu_cmd = 0 selects the ALU's ground channel.
- States: IDLE, SETTLE, HOLD. in_ready = (state == IDLE), combinational from state only. out_valid = (state == HOLD).
- IDLE:
  - On in_valid, latch alu_a = in_use_acc ? acc[15:0] : in_a; alu_b = in_b; alu_cmd = in_cmd.
  - Load settle counter = SETTLE-1 and go to SETTLE.
  - Without in_valid, stay in IDLE and hold all registers.
- SETTLE:
  - alu_a, alu_b and alu_cmd are held constant.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: out_result <= alu_result; out_error <= alu_error; op_count <= op_count+1; go to HOLD.
- Accumulator update at capture: acc <= alu_result only if alu_cmd is 1..5 and alu_error[1] == 0. Otherwise acc is unchanged (divide-by-zero and illegal commands 0, 6..15 never corrupt acc).
- Illegal commands are still sequenced: result and error are captured (the ALU returns 0) and op_count increments.
- sticky_err at capture: sticky_err <= sticky_err | alu_error.
- clr_sticky in a non-capture cycle: sticky_err <= 0.
- clr_sticky in a capture cycle: sticky_err <= alu_error (new errors survive the clear).
- HOLD:
  - out_result and out_error are stable while out_valid is high.
  - On out_ready, go to IDLE; out_valid falls next cycle.
  - No new operation is accepted in the same cycle.
- Latency: handshake accepted at edge N; capture at edge N+SETTLE; out_valid high from cycle N+SETTLE onward. Minimum occupancy per operation = SETTLE+2 cycles.
- Upstream fields are sampled only in the accept cycle. Changes while in_ready is low are ignored.
- Reset during SETTLE or HOLD drops the operation. out_valid falls immediately (asynchronously), and acc, op_count and sticky_err clear.
- Arithmetic: the module performs no arithmetic beyond op_count increment and zero-extension. in_use_acc truncates acc to its low 16 bits.

Test Plan:
1. Reset, SETTLE=2. in_a=249, in_b=69, in_cmd=1, single-cycle in_valid; out_ready=1. Required: out_result=318, out_error=00, out_valid high exactly at cycle N+2; acc=318; op_count=1.
2. Same operands with cmd 2/3/4/5, back to back. Required: results 180, 17181, 3, 42 in order; in_ready low between accept and drain; op_count=5; acc=42.
3. Accumulate: acc=318, then in_use_acc=1, in_b=2, cmd=1. Required: alu_a=318, out_result=320, acc=320.
4. Divide by zero: in_a=5, in_b=0, cmd=4. Required: out_error[1]=1, acc unchanged, sticky_err[1]=1. Then assert clr_sticky alone. Required: sticky_err=00.
5. Backpressure: hold out_ready=0 for 5 cycles in HOLD, toggling in_valid and in_a. Required: out_valid stays 1, out_result constant, in_ready=0, no new accept. Releasing out_ready gives IDLE next cycle.
6. Reset mid-operation: pull rst_n low during SETTLE (counter=1). Required: out_valid=0, acc=0, op_count=0, in_ready=1 after release; no capture occurs. Also check cmd=9 captures 0 with acc unchanged.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequencer around a combinational 16-bit ALU: accepts an op, holds ALU inputs for
// SETTLE cycles, captures result/error and offers it downstream; keeps acc, sticky errors and a count.
module alu_op_sequencer #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [3:0]       in_cmd,
    input  logic             in_use_acc,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [3:0]       alu_cmd,
    input  logic [31:0]      alu_result,
    input  logic [1:0]       alu_error,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [1:0]       out_error,
    output logic [31:0]      acc,
    output logic [1:0]       sticky_err,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [15:0]      alu_a_q;
    logic [15:0]      alu_b_q;
    logic [3:0]       alu_cmd_q;
    logic [31:0]      out_result_q;
    logic [1:0]       out_error_q;
    logic [31:0]      acc_q;
    logic [1:0]       sticky_q;
    logic [1:0]       sticky_d;
    logic [CNT_W-1:0] op_count_q;
    logic             capture;
    logic             cmd_legal;

    assign capture   = (state_q == ST_SETTLE) && (cnt_q == 4'd0);
    assign cmd_legal = (alu_cmd_q >= 4'd1) && (alu_cmd_q <= 4'd5);

    // A clear coinciding with a capture still keeps the errors of that capture.
    always_comb begin
        sticky_d = sticky_q;
        if (capture) begin
            sticky_d = clr_sticky ? alu_error : (sticky_q | alu_error);
        end else if (clr_sticky) begin
            sticky_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            alu_a_q      <= 16'd0;
            alu_b_q      <= 16'd0;
            alu_cmd_q    <= 4'd0;
            out_result_q <= 32'd0;
            out_error_q  <= 2'b00;
            acc_q        <= 32'd0;
            sticky_q     <= 2'b00;
            op_count_q   <= '0;
        end else begin
            sticky_q <= sticky_d;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        alu_a_q   <= in_use_acc ? acc_q[15:0] : in_a;
                        alu_b_q   <= in_b;
                        alu_cmd_q <= in_cmd;
                        cnt_q     <= SETTLE_LOAD;
                        state_q   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        out_result_q <= alu_result;
                        out_error_q  <= alu_error;
                        op_count_q   <= op_count_q + 1'b1;
                        // Divide-by-zero and illegal commands never disturb the accumulator.
                        if (cmd_legal && !alu_error[1]) begin
                            acc_q <= alu_result;
                        end
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_HOLD);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cmd    = alu_cmd_q;
    assign out_result = out_result_q;
    assign out_error  = out_error_q;
    assign acc        = acc_q;
    assign sticky_err = sticky_q;
    assign op_count   = op_count_q;

endmodule
